// File: rtl/ign_seq_pkg.sv
// ---------------------------------------------------------------------------
// ign_seq_pkg
// Shared definitions for the ignition-enable sequencer.
//   state_t : 2-bit FSM state; the encoding is visible on the status port
//             (0 OFF, 1 ARMING, 2 ON, 3 HOLDOFF).
// ---------------------------------------------------------------------------
package ign_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF     = 2'd0,
    ST_ARMING  = 2'd1,
    ST_ON      = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/ign_en_sequencer_if.sv
// ---------------------------------------------------------------------------
// ign_en_sequencer_if
// Bundles the software-facing request/status signals of the sequencer.
//   en_req        : level request from the ign_en PIO
//   wdog_kick     : single-cycle software watchdog refresh
//   fault         : synchronised active-high driver fault
//   fault_clr     : single-cycle pulse clearing the sticky status flags
//   ign_out       : registered ignition-enable drive
//   state         : current FSM state (0 OFF, 1 ARMING, 2 ON, 3 HOLDOFF)
//   fault_latched : sticky fault flag
//   wdog_expired  : sticky watchdog flag
// master = software/PIO side, slave = sequencer.
// ---------------------------------------------------------------------------
interface ign_en_sequencer_if;

  logic       en_req;
  logic       wdog_kick;
  logic       fault;
  logic       fault_clr;
  logic       ign_out;
  logic [1:0] state;
  logic       fault_latched;
  logic       wdog_expired;

  modport master (
    output en_req, wdog_kick, fault, fault_clr,
    input  ign_out, state, fault_latched, wdog_expired
  );

  modport slave (
    input  en_req, wdog_kick, fault, fault_clr,
    output ign_out, state, fault_latched, wdog_expired
  );

endinterface

// File: rtl/ign_seq_timer.sv
// ---------------------------------------------------------------------------
// ign_seq_timer
// CNT_W-bit up-counter with synchronous clear, count enable and saturation
// at all-ones. o_done is a plain equality compare against i_limit.
//   clk, reset : clock and synchronous active-high reset
//   i_clr      : clear to 0 (wins over i_en)
//   i_en       : increment this cycle
//   i_limit    : compare value
//   o_done     : counter == i_limit
// ---------------------------------------------------------------------------
module ign_seq_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == i_limit);

endmodule

// File: rtl/ign_en_sequencer.sv
// ---------------------------------------------------------------------------
// ign_en_sequencer
// Turns the software ignition-enable request into the physical drive with a
// turn-on delay, minimum on/off times, a software watchdog and a latched
// fault shutdown.
//   clk   : system clock
//   reset : synchronous active-high reset (drops ign_out, goes straight OFF)
//   bus   : request/status signals, see ign_en_sequencer_if
// ---------------------------------------------------------------------------
module ign_en_sequencer
  import ign_seq_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int ON_DELAY_CYC = 50000,
  parameter int MIN_ON_CYC   = 500000,
  parameter int MIN_OFF_CYC  = 500000,
  parameter int WDOG_CYC     = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  ign_en_sequencer_if.slave bus
);

  // The phase timer is held at 0 throughout OFF and counts every ARMING
  // cycle, so comparing against ON_DELAY_CYC makes ign_out rise
  // ON_DELAY_CYC+1 edges after the edge that first samples en_req high.
  localparam logic [CNT_W-1:0] ARM_LIM    = CNT_W'(ON_DELAY_CYC);
  localparam logic [CNT_W-1:0] MIN_ON_LIM = CNT_W'(MIN_ON_CYC);
  localparam logic [CNT_W-1:0] OFF_LIM    = CNT_W'((MIN_OFF_CYC > 0) ? MIN_OFF_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] WD_LIM     = CNT_W'((WDOG_CYC > 0) ? WDOG_CYC - 1 : 0);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_ign_out;
  logic             r_fault_latched;
  logic             r_wdog_expired;

  logic             w_set_fault;
  logic             w_set_wdog;
  logic             w_clr_flags;

  logic [CNT_W-1:0] w_ph_limit;
  logic             w_ph_clr;
  logic             w_ph_en;
  logic             w_ph_done;

  logic             w_wd_clr;
  logic             w_wd_en;
  logic             w_wd_done;
  logic             w_wdog_expire;

  // -------------------------------------------------------------------------
  // Phase timer: turn-on delay in ARMING, min-on in ON, min-off in HOLDOFF.
  // Cleared on every state change and for the whole of OFF.
  // -------------------------------------------------------------------------
  always_comb begin
    w_ph_limit = ARM_LIM;
    case (r_state)
      ST_ON:      w_ph_limit = MIN_ON_LIM;
      ST_HOLDOFF: w_ph_limit = OFF_LIM;
      default:    w_ph_limit = ARM_LIM;
    endcase
  end

  assign w_ph_clr = (w_next_state != r_state) || (r_state == ST_OFF);
  // In ON the timer parks on MIN_ON_CYC so done stays high ("min-on elapsed").
  assign w_ph_en  = (r_state == ST_ARMING) || (r_state == ST_HOLDOFF) ||
                    ((r_state == ST_ON) && !w_ph_done);

  ign_seq_timer #(.CNT_W(CNT_W)) u_phase_tmr (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_ph_clr),
    .i_en    (w_ph_en),
    .i_limit (w_ph_limit),
    .o_done  (w_ph_done)
  );

  // -------------------------------------------------------------------------
  // Watchdog: runs only in ON; a kick on the would-be expiry cycle wins.
  // -------------------------------------------------------------------------
  assign w_wd_clr = ((w_next_state == ST_ON) && (r_state != ST_ON)) || bus.wdog_kick;
  assign w_wd_en  = (r_state == ST_ON);
  assign w_wdog_expire = (WDOG_CYC != 0) && (r_state == ST_ON) && w_wd_done && !bus.wdog_kick;

  ign_seq_timer #(.CNT_W(CNT_W)) u_wdog_tmr (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_wd_clr),
    .i_en    (w_wd_en),
    .i_limit (WD_LIM),
    .o_done  (w_wd_done)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_set_fault  = 1'b0;
    w_set_wdog   = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (bus.en_req && !bus.fault && !r_fault_latched && !r_wdog_expired) begin
          w_next_state = ST_ARMING;
        end
      end
      ST_ARMING: begin
        if (!bus.en_req || bus.fault) begin
          w_next_state = ST_OFF;
          w_set_fault  = bus.fault;
        end else if (w_ph_done) begin
          w_next_state = ST_ON;
        end
      end
      ST_ON: begin
        // Fault outranks watchdog, which outranks a normal turn-off.
        if (bus.fault) begin
          w_set_fault  = 1'b1;
          w_next_state = ST_HOLDOFF;
        end else if (w_wdog_expire) begin
          w_set_wdog   = 1'b1;
          w_next_state = ST_HOLDOFF;
        end else if (!bus.en_req && w_ph_done) begin
          w_next_state = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (w_ph_done) begin
          w_next_state = ST_OFF;
        end
      end
      default: w_next_state = ST_OFF;
    endcase
  end

  // A clear request is ignored while the fault input is still active.
  assign w_clr_flags = bus.fault_clr && !bus.fault;

  // -------------------------------------------------------------------------
  // State, drive and sticky flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_OFF;
      r_ign_out       <= 1'b0;
      r_fault_latched <= 1'b0;
      r_wdog_expired  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ign_out <= (w_next_state == ST_ON);
      // Set wins over a same-cycle clear.
      if (w_set_fault) begin
        r_fault_latched <= 1'b1;
      end else if (w_clr_flags) begin
        r_fault_latched <= 1'b0;
      end
      if (w_set_wdog) begin
        r_wdog_expired <= 1'b1;
      end else if (w_clr_flags) begin
        r_wdog_expired <= 1'b0;
      end
    end
  end

  assign bus.ign_out       = r_ign_out;
  assign bus.state         = r_state;
  assign bus.fault_latched = r_fault_latched;
  assign bus.wdog_expired  = r_wdog_expired;

endmodule

// File: tb/tb_ign_en_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ign_en_sequencer
// Self-checking bench. Each step drives inputs on the falling edge and
// queues the outputs expected right after the next rising edge; a monitor
// pops and compares one entry per rising edge.
// Timing (ON_DELAY=4, MIN_ON=8, MIN_OFF=6, WDOG=10):
//   en_req first sampled at E0 -> ARMING after E0, ON/ign_out at E0+5.
//   ON entered at E1           -> earliest normal exit at E1+9,
//                                 watchdog expiry at E1+10.
//   HOLDOFF entered at Eh      -> OFF at Eh+6.
// ---------------------------------------------------------------------------
module tb_ign_en_sequencer;
  import ign_seq_pkg::*;

  localparam int ON_D    = 4;
  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 6;
  localparam int WDOG    = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ign_en_sequencer_if bus ();

  ign_en_sequencer #(
    .CNT_W        (24),
    .ON_DELAY_CYC (ON_D),
    .MIN_ON_CYC   (MIN_ON),
    .MIN_OFF_CYC  (MIN_OFF),
    .WDOG_CYC     (WDOG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic   rst, en, kick, f, fc;
    state_t st;
    logic   ign, fl, we;
    string  tag;
  } vec_t;

  typedef struct {
    state_t st;
    logic   ign, fl, we;
    string  tag;
    int     idx;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb_q[$];
  string tag_now;
  int    seq_no  = 0;
  int    n_checks = 0;
  int    n_fail   = 0;

  // Append n identical one-cycle vectors to the table.
  task automatic add(input int n, input logic rst, en, kick, f, fc,
                     input state_t st, input logic ign, fl, we);
    vec_t v;
    v.rst = rst; v.en = en; v.kick = kick; v.f = f; v.fc = fc;
    v.st = st; v.ign = ign; v.fl = fl; v.we = we; v.tag = tag_now;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rst, en, kick, f, fc,
                      input state_t st, input logic ign, fl, we, input string tag);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    bus.en_req    = en;
    bus.wdog_kick = kick;
    bus.fault     = f;
    bus.fault_clr = fc;
    e.st = st; e.ign = ign; e.fl = fl; e.we = we; e.tag = tag; e.idx = seq_no;
    seq_no++;
    sb_q.push_back(e);
  endtask

  // Request held until ON is reached (5 ARMING cycles then ON).
  task automatic go_on(input string tag);
    for (int i = 0; i < ON_D + 1; i++) step(0, 1, 0, 0, 0, ST_ARMING, 0, 0, 0, tag);
    step(0, 1, 0, 0, 0, ST_ON, 1, 0, 0, tag);
  endtask

  // Monitor / scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (bus.state !== 2'(e.st) || bus.ign_out !== e.ign ||
            bus.fault_latched !== e.fl || bus.wdog_expired !== e.we) begin
          n_fail++;
          $display("FAIL %s #%0d: got state=%0d ign=%0b fl=%0b we=%0b, expected state=%0d ign=%0b fl=%0b we=%0b",
                   e.tag, e.idx, bus.state, bus.ign_out, bus.fault_latched, bus.wdog_expired,
                   2'(e.st), e.ign, e.fl, e.we);
        end else begin
          $display("ok   %s #%0d: state=%0d ign=%0b fl=%0b we=%0b",
                   e.tag, e.idx, bus.state, bus.ign_out, bus.fault_latched, bus.wdog_expired);
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.en_req    = 1'b0;
    bus.wdog_kick = 1'b0;
    bus.fault     = 1'b0;
    bus.fault_clr = 1'b0;

    // ------------------------------------------------------------------
    // Vector table: n, rst,en,kick,f,fc, state,ign,fl,we
    // ------------------------------------------------------------------
    tag_now = "reset";
    add(2, 1,0,0,0,0, ST_OFF,     0,0,0);
    add(1, 0,0,0,0,0, ST_OFF,     0,0,0);

    tag_now = "normal_cycle";                // E0 = first vector below
    add(5, 0,1,0,0,0, ST_ARMING,  0,0,0);    // E0..E0+4
    add(5, 0,1,0,0,0, ST_ON,      1,0,0);    // E0+5..E0+9
    add(1, 0,1,1,0,0, ST_ON,      1,0,0);    // E0+10 kick
    add(4, 0,1,0,0,0, ST_ON,      1,0,0);
    add(1, 0,1,1,0,0, ST_ON,      1,0,0);    // E0+15 kick
    add(4, 0,1,0,0,0, ST_ON,      1,0,0);
    add(1, 0,1,1,0,0, ST_ON,      1,0,0);    // E0+20 kick
    add(1, 0,0,0,0,0, ST_HOLDOFF, 0,0,0);    // E0+21 en_req low
    add(5, 0,0,0,0,0, ST_HOLDOFF, 0,0,0);
    add(1, 0,0,0,0,0, ST_OFF,     0,0,0);    // E0+27

    tag_now = "short_pulse";
    add(3, 0,1,0,0,0, ST_ARMING,  0,0,0);
    add(2, 0,0,0,0,0, ST_OFF,     0,0,0);

    tag_now = "min_on";                      // ON entered at E1
    add(5, 0,1,0,0,0, ST_ARMING,  0,0,0);
    add(1, 0,1,0,0,0, ST_ON,      1,0,0);    // E1
    add(2, 0,1,0,0,0, ST_ON,      1,0,0);
    add(2, 0,0,0,0,0, ST_ON,      1,0,0);    // dropped, min-on holds
    add(1, 0,0,1,0,0, ST_ON,      1,0,0);    // E1+5 kick
    add(3, 0,0,0,0,0, ST_ON,      1,0,0);    // through E1+8
    add(1, 0,0,0,0,0, ST_HOLDOFF, 0,0,0);    // E1+9
    add(5, 0,1,0,0,0, ST_HOLDOFF, 0,0,0);    // re-request ignored
    add(1, 0,1,0,0,0, ST_OFF,     0,0,0);
    add(1, 0,1,0,0,0, ST_ARMING,  0,0,0);
    add(1, 0,0,0,0,0, ST_OFF,     0,0,0);

    tag_now = "arming_fault";
    add(1, 0,1,0,0,0, ST_ARMING,  0,0,0);
    add(1, 0,1,0,1,0, ST_OFF,     0,1,0);
    add(1, 0,1,0,0,0, ST_OFF,     0,1,0);    // latched flag blocks arming
    add(1, 0,1,0,0,1, ST_OFF,     0,0,0);
    add(1, 0,1,0,0,0, ST_ARMING,  0,0,0);
    add(1, 0,0,0,0,0, ST_OFF,     0,0,0);

    tag_now = "on_fault";
    add(5, 0,1,0,0,0, ST_ARMING,  0,0,0);
    add(3, 0,1,0,0,0, ST_ON,      1,0,0);
    add(1, 0,1,0,1,0, ST_HOLDOFF, 0,1,0);    // Ef
    add(5, 0,1,0,0,0, ST_HOLDOFF, 0,1,0);
    add(3, 0,1,0,0,0, ST_OFF,     0,1,0);    // no re-arm
    add(1, 0,1,0,1,1, ST_OFF,     0,1,0);    // clear ignored while fault=1
    add(1, 0,1,0,0,1, ST_OFF,     0,0,0);
    add(1, 0,1,0,0,0, ST_ARMING,  0,0,0);
    add(1, 0,0,0,0,0, ST_OFF,     0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].kick, vecs[i].f, vecs[i].fc,
           vecs[i].st, vecs[i].ign, vecs[i].fl, vecs[i].we, vecs[i].tag);
    end

    // ------------------------------------------------------------------
    // Watchdog expiry with no kicks: exactly WDOG cycles after ON entry.
    // ------------------------------------------------------------------
    go_on("wdog_expire");
    for (int i = 0; i < WDOG - 1; i++) step(0, 1, 0, 0, 0, ST_ON, 1, 0, 0, "wdog_expire");
    step(0, 1, 0, 0, 0, ST_HOLDOFF, 0, 0, 1, "wdog_expire");
    for (int i = 0; i < MIN_OFF - 1; i++) step(0, 0, 0, 0, 0, ST_HOLDOFF, 0, 0, 1, "wdog_expire");
    step(0, 0, 0, 0, 0, ST_OFF, 0, 0, 1, "wdog_expire");
    step(0, 1, 0, 0, 0, ST_OFF, 0, 0, 1, "wdog_expire");
    step(0, 1, 0, 0, 1, ST_OFF, 0, 0, 0, "wdog_expire");
    step(0, 0, 0, 0, 0, ST_OFF, 0, 0, 0, "wdog_expire");

    // Kick on the expiry cycle wins; the next full window expires, and a
    // same-cycle fault_clr loses against the set.
    go_on("wdog_kick_edge");
    for (int i = 0; i < WDOG - 1; i++) step(0, 1, 0, 0, 0, ST_ON, 1, 0, 0, "wdog_kick_edge");
    step(0, 1, 1, 0, 0, ST_ON, 1, 0, 0, "wdog_kick_edge");
    for (int i = 0; i < WDOG - 1; i++) step(0, 1, 0, 0, 0, ST_ON, 1, 0, 0, "wdog_kick_edge");
    step(0, 1, 0, 0, 1, ST_HOLDOFF, 0, 0, 1, "wdog_kick_edge");
    for (int i = 0; i < MIN_OFF - 1; i++) step(0, 0, 0, 0, 0, ST_HOLDOFF, 0, 0, 1, "wdog_kick_edge");
    step(0, 0, 0, 0, 0, ST_OFF, 0, 0, 1, "wdog_kick_edge");
    step(0, 0, 0, 0, 1, ST_OFF, 0, 0, 0, "wdog_kick_edge");

    // Fault and watchdog expiry on the same cycle: only the fault flag.
    go_on("fault_vs_wdog");
    for (int i = 0; i < WDOG - 1; i++) step(0, 1, 0, 0, 0, ST_ON, 1, 0, 0, "fault_vs_wdog");
    step(0, 1, 0, 1, 0, ST_HOLDOFF, 0, 1, 0, "fault_vs_wdog");
    for (int i = 0; i < MIN_OFF - 1; i++) step(0, 0, 0, 0, 0, ST_HOLDOFF, 0, 1, 0, "fault_vs_wdog");
    step(0, 0, 0, 0, 0, ST_OFF, 0, 1, 0, "fault_vs_wdog");
    step(0, 0, 0, 0, 1, ST_OFF, 0, 0, 0, "fault_vs_wdog");

    // Reset while ON: straight to OFF, then re-arm on the first free edge.
    go_on("reset_in_on");
    step(0, 1, 0, 0, 0, ST_ON,     1, 0, 0, "reset_in_on");
    step(0, 1, 0, 0, 0, ST_ON,     1, 0, 0, "reset_in_on");
    step(1, 1, 0, 0, 0, ST_OFF,    0, 0, 0, "reset_in_on");
    step(0, 1, 0, 0, 0, ST_ARMING, 0, 0, 0, "reset_in_on");
    step(0, 0, 0, 0, 0, ST_OFF,    0, 0, 0, "reset_in_on");

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
